// File: rtl/jk_mon_pkg.sv
// Shared types and helpers for the JK flop pulse monitor.
// State encoding, default counter width and saturating increment.
package jk_mon_pkg;

  typedef enum logic [1:0] {
    START,
    PARTIAL,
    LOW,
    HIGH
  } state_t;

  localparam int CNT_W_DEF = 8;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/jk_pulse_meter_if.sv
// Width result handshake between the pulse meter and its consumer.
// The meter drives width/width_valid, the consumer drives width_ready.
interface jk_pulse_meter_if
  import jk_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] width;
  logic             width_valid;
  logic             width_ready;

  modport master (
    output width,
    output width_valid,
    input  width_ready
  );

  modport slave (
    input  width,
    input  width_valid,
    output width_ready
  );

endinterface

// File: rtl/jk_edge_det.sv
// Sampled edge detector on the flop output q.
// Strobes are suppressed until the monitor has seen its first sample.
module jk_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic q,
  input  logic arm,
  output logic rise,
  output logic fall,
  output logic trans
);

  logic q_s;

  assign trans = arm & (q ^ q_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_s  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q_s  <= q;
      rise <= trans & q;
      fall <= trans & ~q;
    end
  end

endmodule

// File: rtl/jk_pulse_meter.sv
// Pulse monitor for the JK flop stage: strobes, toggle count,
// high-pulse width measurement with handshake, sticky errors.
module jk_pulse_meter
  import jk_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q,
  input  logic             qb,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] toggles,
  output logic             overrun,
  output logic             err,
  jk_pulse_meter_if.master wif
);

  localparam logic [31:0] MAX =
    32'((64'd1 << CNT_W) - 64'd1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             arm;
  logic             trans;
  logic             cap;
  logic             take;
  logic             ovr_ev;
  logic             bad;

  assign arm = (state != START);

  jk_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .arm   (arm),
    .rise  (rise),
    .fall  (fall),
    .trans (trans)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= START;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    unique case (state)
      START: state_nxt = q ? PARTIAL : LOW;
      PARTIAL: begin
        if (!q) state_nxt = LOW;
      end
      LOW: begin
        if (q) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (q) begin
          cnt_nxt = CNT_W'(sat_inc(32'(cnt), MAX));
        end else begin
          state_nxt = LOW;
          cap       = 1'b1;
        end
      end
      default: state_nxt = START;
    endcase
  end

  // A pending result may be replaced only if it is consumed now
  assign take   = cap & (~wif.width_valid | wif.width_ready);
  assign ovr_ev = cap & ~take;
  assign bad    = (q == qb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt             <= '0;
      wif.width       <= '0;
      wif.width_valid <= 1'b0;
      toggles         <= '0;
      overrun         <= 1'b0;
      err             <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (take) begin
        wif.width       <= cnt;
        wif.width_valid <= 1'b1;
      end else if (wif.width_valid & wif.width_ready) begin
        wif.width_valid <= 1'b0;
      end
      if (clr) begin
        toggles <= trans ? CNT_W'(1) : '0;
      end else if (trans) begin
        toggles <= CNT_W'(sat_inc(32'(toggles), MAX));
      end
      overrun <= ovr_ev | (overrun & ~clr);
      err     <= bad | (err & ~clr);
    end
  end

endmodule
